remote_comm: RTL and testbench

- Host-side serial command link used by the Knight's Tour bench and remote controller.
- Accepts a 16-bit command and transmits it to the robot over a UART line, high byte first.
- Receives the robot's one-byte response (0xA5 positive ack) on a second UART line.
- Contains one UART transmitter with a byte sequencer, and one UART receiver.

---
 rtl/remote_comm.sv | 169 ++++++++++++++++
 tb/tb_remote_comm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// Host-side serial command link: 16-bit command out as two 8N1 bytes
// (high first), single-byte response in on a separate UART line.
module remote_comm #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic [15:0] cmd,
   input  logic        snd_cmd,
   output logic        cmd_snt,
   output logic        resp_rdy,
   output logic [7:0]  resp
);

   localparam int CW = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW, TX_DONE} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   tx_state_t     tx_state, tx_nxt;
   logic [CW-1:0] tx_baud;
   logic [3:0]    tx_bits;
   logic [9:0]    tx_shift;
   logic [7:0]    low_byte;
   logic          tx_bit_end, tx_byte_end, tx_start, tx_busy;

   rx_state_t     rx_state, rx_nxt;
   logic [CW-1:0] rx_baud;
   logic [2:0]    rx_bits;
   logic [7:0]    rx_shift;
   logic [1:0]    rx_sync_q;
   logic          rx_sync, rx_bit_end, rx_half_end;

   // ---------------- send path ----------------
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) tx_state <= TX_IDLE;
      else       tx_state <= tx_nxt;
   end

   always_comb begin
      tx_bit_end  = (tx_baud == BIT_LAST);
      tx_byte_end = tx_bit_end && (tx_bits == 4'd9);
      tx_busy     = (tx_state == TX_HIGH) || (tx_state == TX_LOW);
      tx_start    = 1'b0;
      tx_nxt      = tx_state;
      case (tx_state)
         TX_IDLE: if (snd_cmd) begin
            tx_start = 1'b1;
            tx_nxt   = TX_HIGH;
         end
         TX_HIGH: if (tx_byte_end) tx_nxt = TX_LOW;
         TX_LOW:  if (tx_byte_end) tx_nxt = TX_DONE;
         TX_DONE: tx_nxt = TX_IDLE;
         default: tx_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         tx_baud  <= '0;
         tx_bits  <= '0;
         tx_shift <= '1;
         low_byte <= '0;
         cmd_snt  <= 1'b0;
      end else if (tx_start) begin
         low_byte <= cmd[7:0];
         tx_shift <= {1'b1, cmd[15:8], 1'b0};
         tx_baud  <= '0;
         tx_bits  <= '0;
         cmd_snt  <= 1'b0;
      end else if (tx_busy) begin
         if (tx_bit_end) begin
            tx_baud <= '0;
            // reload the low byte straight after the stop bit: no idle gap
            if (tx_bits == 4'd9) begin
               tx_bits  <= '0;
               tx_shift <= {1'b1, low_byte, 1'b0};
            end else begin
               tx_bits  <= tx_bits + 4'd1;
               tx_shift <= {1'b1, tx_shift[9:1]};
            end
         end else begin
            tx_baud <= tx_baud + 1'b1;
         end
      end else if (tx_state == TX_DONE) begin
         cmd_snt <= 1'b1;
      end
   end

   assign TX = tx_busy ? tx_shift[0] : 1'b1;

   // ---------------- receive path ----------------
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) rx_sync_q <= 2'b11;
      else       rx_sync_q <= {rx_sync_q[0], RX};
   end

   assign rx_sync = rx_sync_q[1];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) rx_state <= RX_IDLE;
      else       rx_state <= rx_nxt;
   end

   always_comb begin
      rx_bit_end  = (rx_baud == BIT_LAST);
      rx_half_end = (rx_baud == HALF_LAST);
      rx_nxt      = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_sync) rx_nxt = RX_START;
         RX_START: if (rx_half_end) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_bit_end && rx_bits == 3'd7) rx_nxt = RX_STOP;
         RX_STOP:  if (rx_bit_end) rx_nxt = RX_IDLE;
         default:  rx_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rx_baud  <= '0;
         rx_bits  <= '0;
         rx_shift <= '0;
         resp     <= '0;
         resp_rdy <= 1'b0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               rx_baud <= '0;
               rx_bits <= '0;
            end
            RX_START: begin
               // only a start bit that survives to mid-bit drops resp_rdy
               if (rx_half_end) begin
                  rx_baud <= '0;
                  if (!rx_sync) resp_rdy <= 1'b0;
               end else begin
                  rx_baud <= rx_baud + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_bit_end) begin
                  rx_baud  <= '0;
                  rx_bits  <= rx_bits + 3'd1;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
               end else begin
                  rx_baud <= rx_baud + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_bit_end) begin
                  rx_baud <= '0;
                  if (rx_sync) begin
                     resp     <= rx_shift;
                     resp_rdy <= 1'b1;
                  end
               end else begin
                  rx_baud <= rx_baud + 1'b1;
               end
            end
            default: rx_baud <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: scoreboard queues for TX bytes and RX responses,
// checked by independent monitor processes.
module tb_remote_comm;

   localparam int B = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        RX = 1'b1;
   logic        TX;
   logic [15:0] cmd = '0;
   logic        snd_cmd = 1'b0;
   logic        cmd_snt;
   logic        resp_rdy;
   logic [7:0]  resp;

   int total = 0;
   int bad = 0;
   bit mon_en = 1'b0;

   logic [7:0] txq[$];
   logic [7:0] rxq[$];

   remote_comm #(.BAUD_DIV(B)) dut (
      .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
      .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
      .resp_rdy(resp_rdy), .resp(resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] c);
      @(negedge clk);
      cmd = c;
      snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
      cmd = ~c;
   endtask

   task automatic wait_snt(output int n);
      n = 1;
      while (!cmd_snt && n < 30 * B) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_snt_timeout", cmd_snt, 1);
   endtask

   task automatic drive_rx(input logic [7:0] b, input logic stopb);
      @(negedge clk);
      RX = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (B) @(negedge clk);
      end
      RX = stopb;
      repeat (B) @(negedge clk);
      RX = 1'b1;
   endtask

   // reference UART receiver on TX
   initial begin
      logic [7:0] d;
      forever begin
         @(negedge clk iff (mon_en && TX == 1'b0));
         repeat (B / 2) @(negedge clk);
         chk("tx_start_bit", TX, 0);
         for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            d[i] = TX;
         end
         repeat (B) @(negedge clk);
         chk("tx_stop_bit", TX, 1);
         total++;
         if (txq.size() == 0) begin
            bad++;
            $display("FAIL tx_unexpected: got %h want none", d);
         end else begin
            logic [7:0] e;
            e = txq.pop_front();
            if (d !== e) begin
               bad++;
               $display("FAIL tx_byte: got %h want %h", d, e);
            end
         end
      end
   end

   // response monitor
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_rdy && !prev) begin
            total++;
            if (rxq.size() == 0) begin
               bad++;
               $display("FAIL rx_unexpected: got %h want none", resp);
            end else begin
               logic [7:0] e;
               e = rxq.pop_front();
               if (resp !== e) begin
                  bad++;
                  $display("FAIL rx_resp: got %h want %h", resp, e);
               end
            end
         end
         prev = resp_rdy;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (5) @(negedge clk);
      chk("rst_tx", TX, 1);
      chk("rst_snt", cmd_snt, 0);
      chk("rst_rdy", resp_rdy, 0);
      chk("rst_resp", resp, 8'h00);
      rst_n = 1'b0;

      // reset with a byte in flight
      send(16'h5555);
      repeat (25) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_tx", TX, 1);
      chk("midrst_snt", cmd_snt, 0);
      chk("midrst_rdy", resp_rdy, 0);
      chk("midrst_resp", resp, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (12 * B) @(negedge clk);
      chk("idle_tx", TX, 1);
      mon_en = 1'b1;

      // send 43F1, timing and cmd_snt behaviour
      txq.push_back(8'h43);
      txq.push_back(8'hF1);
      send(16'h43F1);
      wait_snt(n);
      chk("snt_time", ((n - 1) >= 20 * B - 1) && ((n - 1) <= 20 * B + 1), 1);
      txq.push_back(8'h20);
      txq.push_back(8'h00);
      send(16'h2000);
      chk("snt_clear", cmd_snt, 0);
      repeat (3 * B) @(negedge clk);
      snd_cmd = 1'b1;
      cmd = 16'hFFFF;
      @(negedge clk);
      snd_cmd = 1'b0;
      wait_snt(n);
      repeat (3 * B) @(negedge clk);
      chk("txq_drained_1", txq.size(), 0);

      // receive A5 then 5A
      rxq.push_back(8'hA5);
      drive_rx(8'hA5, 1'b1);
      repeat (4) @(negedge clk);
      chk("rdy_a5", resp_rdy, 1);
      chk("resp_a5", resp, 8'hA5);
      rxq.push_back(8'h5A);
      fork
         drive_rx(8'h5A, 1'b1);
         begin
            repeat (B) @(negedge clk);
            chk("rdy_drop", resp_rdy, 0);
            chk("resp_hold", resp, 8'hA5);
         end
      join
      repeat (4) @(negedge clk);
      chk("resp_5a", resp, 8'h5A);

      // one-clock glitch
      @(negedge clk);
      RX = 1'b0;
      @(negedge clk);
      RX = 1'b1;
      repeat (2 * B) @(negedge clk);
      chk("glitch_rdy", resp_rdy, 1);
      chk("glitch_resp", resp, 8'h5A);

      // framing error
      drive_rx(8'h3C, 1'b0);
      repeat (2 * B) @(negedge clk);
      chk("frame_resp", resp, 8'h5A);

      // full duplex
      txq.push_back(8'h12);
      txq.push_back(8'h34);
      rxq.push_back(8'hA5);
      fork
         send(16'h1234);
         drive_rx(8'hA5, 1'b1);
      join
      wait_snt(n);
      repeat (2 * B) @(negedge clk);
      chk("duplex_resp", resp, 8'hA5);
      chk("duplex_rdy", resp_rdy, 1);
      chk("txq_drained_2", txq.size(), 0);
      chk("rxq_drained", rxq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
